// File: rtl/hex_entry.sv
// ============================================================================
// hex_entry : UART byte stream -> 4-digit hex edit buffer for a 7-seg display
// Optional echo channel enabled by defining ECHO_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module hex_entry #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        IN_clk,
    input  logic        IN_rst,
    input  logic [7:0]  IN_rx_data,
    input  logic        IN_rx_valid,
    output logic [15:0] OUT_value,
    output logic [2:0]  OUT_off_number,
    output logic [15:0] OUT_commit_value,
    output logic        OUT_commit,
    output logic        OUT_err,
    output logic        OUT_scan_clk
`ifdef ECHO_EN
    ,
    output logic [7:0]  OUT_tx_data,
    output logic        OUT_tx_valid,
    input  logic        IN_tx_busy
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_EDIT  = 2'd1,
        S_FULL  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] cval_d;
    logic        commit_d;
    logic        accept_d;
    logic        is_hex, is_bs, is_esc, is_cr;
    logic [3:0]  nibble;
    logic [15:0] value_d;
    logic [2:0]  off_d;

    always_comb begin
        is_bs  = (IN_rx_data == 8'h08);
        is_esc = (IN_rx_data == 8'h1B);
        is_cr  = (IN_rx_data == 8'h0D);
        is_hex = 1'b0;
        nibble = 4'h0;
        if (IN_rx_data >= 8'h30 && IN_rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = IN_rx_data[3:0];
        end else if (IN_rx_data >= 8'h41 && IN_rx_data <= 8'h46) begin
            is_hex = 1'b1;
            nibble = IN_rx_data[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        cval_d   = OUT_commit_value;
        commit_d = 1'b0;
        accept_d = 1'b0;
        if (IN_rx_valid) begin
            if (state_q == S_ERR) begin
                // Only ESC leaves ERR; everything else is swallowed.
                if (is_esc) begin
                    state_d  = S_EMPTY;
                    buf_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    accept_d = 1'b1;
                end
            end else if (is_hex) begin
                if (cnt_q == 3'd4) begin
                    state_d = S_ERR;
                end else begin
                    buf_d    = {buf_q[11:0], nibble};
                    cnt_d    = cnt_q + 3'd1;
                    state_d  = (cnt_q == 3'd3) ? S_FULL : S_EDIT;
                    accept_d = 1'b1;
                end
            end else if (is_bs) begin
                if (cnt_q != 3'd0) begin
                    buf_d    = {4'h0, buf_q[15:4]};
                    cnt_d    = cnt_q - 3'd1;
                    state_d  = (cnt_q == 3'd1) ? S_EMPTY : S_EDIT;
                    accept_d = 1'b1;
                end
            end else if (is_esc) begin
                state_d  = S_EMPTY;
                buf_d    = 16'h0000;
                cnt_d    = 3'd0;
                accept_d = 1'b1;
            end else if (is_cr) begin
                cval_d   = buf_q;
                commit_d = 1'b1;
                accept_d = 1'b1;
            end else begin
                state_d = S_ERR;
            end
        end

        if (state_d == S_ERR) begin
            value_d = 16'hEEEE;
            off_d   = 3'd0;
        end else begin
            value_d = buf_d;
            off_d   = (cnt_d == 3'd0) ? 3'd3 : (3'd4 - cnt_d);
        end
    end

    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            state_q          <= S_EMPTY;
            buf_q            <= 16'h0000;
            cnt_q            <= 3'd0;
            OUT_value        <= 16'h0000;
            OUT_off_number   <= 3'd3;
            OUT_commit_value <= 16'h0000;
            OUT_commit       <= 1'b0;
            OUT_err          <= 1'b0;
        end else begin
            state_q          <= state_d;
            buf_q            <= buf_d;
            cnt_q            <= cnt_d;
            OUT_value        <= value_d;
            OUT_off_number   <= off_d;
            OUT_commit_value <= cval_d;
            OUT_commit       <= commit_d;
            OUT_err          <= (state_d == S_ERR);
        end
    end

    logic [CNT_W-1:0] scan_cnt_q;

    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            scan_cnt_q   <= '0;
            OUT_scan_clk <= 1'b0;
        end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_q   <= '0;
            OUT_scan_clk <= ~OUT_scan_clk;
        end else begin
            scan_cnt_q   <= scan_cnt_q + 1'b1;
        end
    end

`ifdef ECHO_EN
    logic       tx_full_q;
    logic [7:0] tx_buf_q;

    // A full buffer keeps its byte; anything arriving meanwhile is dropped.
    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            tx_full_q    <= 1'b0;
            tx_buf_q     <= 8'h00;
            OUT_tx_data  <= 8'h00;
            OUT_tx_valid <= 1'b0;
        end else begin
            OUT_tx_valid <= 1'b0;
            if (tx_full_q) begin
                if (!IN_tx_busy) begin
                    OUT_tx_valid <= 1'b1;
                    OUT_tx_data  <= tx_buf_q;
                    tx_full_q    <= 1'b0;
                end
            end else if (IN_rx_valid) begin
                tx_full_q <= 1'b1;
                tx_buf_q  <= accept_d ? IN_rx_data : 8'h07;
            end
        end
    end
`endif

endmodule

`default_nettype wire
